// File: rtl/mat_host_pkg.sv
// Shared types and constants for the matrix-multiply host driver.
//   host_state_t : driver FSM states (IDLE, LOAD, FIRE, WAIT, COLLECT, DONE)
//   DATA_W       : operand element width
//   ACC_W        : result element width
package mat_host_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FIRE,
      WAIT,
      COLLECT,
      DONE
   } host_state_t;

endpackage

// File: rtl/mat_result_collector.sv
// Result collector: captures the multiplier's result words into a packed
// M*M result vector and tracks how long it has been since the last word.
//   CLK, rst : clock, synchronous active-high reset
//   clear    : zero the result, index and silence counter for a new job
//   enable   : high while the driver is waiting for / collecting results
//   c        : result word from the multiplier
//   vld_out  : c is valid
//   full     : the last element is captured this cycle (or already held)
//   timeout  : no word arrived and the silence limit is reached this cycle
//   result   : packed result, element k at bits [16k+15:16k]
module mat_result_collector
   import mat_host_pkg::*;
#(
   parameter int M       = 3,
   parameter int TIMEOUT = 1024   // must be at least 2
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [ACC_W-1:0]     c,
   input  logic                 vld_out,
   output logic                 full,
   output logic                 timeout,
   output logic [ACC_W*M*M-1:0] result
);

   localparam int N     = M * M;
   localparam int IDX_W = $clog2(N + 1);
   localparam int AGE_W = $clog2(TIMEOUT + 1);

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(N);
   // age = cycles since the last word (or since the fire handshake),
   // counting the current cycle; the cycle after the event has age 1.
   localparam logic [AGE_W-1:0] AGE_START = AGE_W'(1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT - 1);

   logic [IDX_W-1:0]         idx;
   logic [AGE_W-1:0]         age;
   logic [N-1:0][ACC_W-1:0]  words;
   logic                     accept;

   // Words past the last element are dropped.
   assign accept  = enable && vld_out && (idx != IDX_FULL);
   assign full    = (idx == IDX_FULL) || (accept && (idx == IDX_LAST));
   // A word in the expiry cycle wins over the timeout.
   assign timeout = enable && !accept && (age == AGE_LIMIT);
   assign result  = words;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge CLK) begin
      if (rst || clear) begin
         idx   <= '0;
         age   <= AGE_START;
         words <= '0;
      end else if (accept) begin
         words[idx] <= c;
         idx        <= idx + IDX_W'(1);
         age        <= AGE_START;
      end else if (enable) begin
         age <= age + AGE_W'(1);
      end else begin
         age <= AGE_START;
      end
   end

endmodule

// File: rtl/mat_host_if.sv
// Host-side driver for the serial systolic matrix multiplier. Takes two
// packed M*M byte matrices on a valid/ready handshake, streams them element
// by element onto a/b, fires the multiplier, then gathers the M*M result
// words into a packed result vector offered upstream with res_vld/res_rdy.
//   CLK, rst            : clock, synchronous active-high reset
//   start_vld/start_rdy : job handshake; mat_a/mat_b sampled on acceptance
//   mat_a, mat_b        : packed operands, element k at bits [8k+7:8k]
//   result, err         : packed product and timeout flag, valid with res_vld
//   res_vld/res_rdy     : result handshake
//   a, b, vld_in        : operand stream to the multiplier (vld_in=1 fires)
//   rdy_in              : multiplier accepted the fire
//   c, vld_out, rdy_out : result stream from the multiplier
module mat_host_if
   import mat_host_pkg::*;
#(
   parameter int M       = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  start_vld,
   output logic                  start_rdy,
   input  logic [DATA_W*M*M-1:0] mat_a,
   input  logic [DATA_W*M*M-1:0] mat_b,
   output logic [ACC_W*M*M-1:0]  result,
   output logic                  res_vld,
   input  logic                  res_rdy,
   output logic                  err,
   output logic [DATA_W-1:0]     a,
   output logic [DATA_W-1:0]     b,
   output logic                  vld_in,
   input  logic                  rdy_in,
   input  logic [ACC_W-1:0]      c,
   input  logic                  vld_out,
   output logic                  rdy_out
);

   localparam int N   = M * M;
   localparam int K_W = $clog2(N + 1);
   localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

   host_state_t             state, state_next;
   logic [K_W-1:0]          k, k_next;
   logic [DATA_W-1:0]       a_next, b_next;
   logic                    vld_in_next, rdy_out_next, res_vld_next, err_next;
   logic                    clear, load_sh, shift_sh;
   logic                    enable, full, timeout;
   // Elements still to be sent; element 0 leaves through a/b directly.
   logic [DATA_W*N-1:0]     sh_a, sh_b;

   assign start_rdy = (state == IDLE);
   assign enable    = (state == WAIT) || (state == COLLECT);

   mat_result_collector #(
      .M       (M),
      .TIMEOUT (TIMEOUT)
   ) u_collector (
      .CLK     (CLK),
      .rst     (rst),
      .clear   (clear),
      .enable  (enable),
      .c       (c),
      .vld_out (vld_out),
      .full    (full),
      .timeout (timeout),
      .result  (result)
   );

   // Outputs are computed one cycle ahead so they can all be registered.
   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next   = state;
      k_next       = k;
      a_next       = '0;
      b_next       = '0;
      vld_in_next  = 1'b0;
      rdy_out_next = 1'b0;
      res_vld_next = 1'b0;
      err_next     = err;
      clear        = 1'b0;
      load_sh      = 1'b0;
      shift_sh     = 1'b0;
      case (state)
         IDLE: begin
            if (start_vld) begin
               clear      = 1'b1;
               load_sh    = 1'b1;
               err_next   = 1'b0;
               k_next     = '0;
               a_next     = mat_a[DATA_W-1:0];
               b_next     = mat_b[DATA_W-1:0];
               state_next = LOAD;
            end
         end
         LOAD: begin
            // k is the element currently on a/b.
            if (k == K_LAST) begin
               vld_in_next = 1'b1;
               state_next  = FIRE;
            end else begin
               a_next   = sh_a[DATA_W-1:0];
               b_next   = sh_b[DATA_W-1:0];
               shift_sh = 1'b1;
               k_next   = k + K_W'(1);
            end
         end
         FIRE: begin
            if (rdy_in) begin
               rdy_out_next = 1'b1;
               state_next   = WAIT;
            end else begin
               vld_in_next = 1'b1;
            end
         end
         WAIT, COLLECT: begin
            if (full) begin
               res_vld_next = 1'b1;
               state_next   = DONE;
            end else if (timeout) begin
               err_next     = 1'b1;
               res_vld_next = 1'b1;
               state_next   = DONE;
            end else begin
               rdy_out_next = 1'b1;
               if (vld_out) state_next = COLLECT;
            end
         end
         DONE: begin
            if (res_rdy) state_next = IDLE;
            else         res_vld_next = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state   <= IDLE;
         k       <= '0;
         a       <= '0;
         b       <= '0;
         vld_in  <= 1'b0;
         rdy_out <= 1'b0;
         res_vld <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_next;
         k       <= k_next;
         a       <= a_next;
         b       <= b_next;
         vld_in  <= vld_in_next;
         rdy_out <= rdy_out_next;
         res_vld <= res_vld_next;
         err     <= err_next;
      end
   end

   // NOTE: the operand shifter has no reset; it is always loaded on job
   // acceptance before any of its contents reach a/b.
   always_ff @(posedge CLK) begin
      if (load_sh) begin
         sh_a <= mat_a >> DATA_W;
         sh_b <= mat_b >> DATA_W;
      end else if (shift_sh) begin
         sh_a <= sh_a >> DATA_W;
         sh_b <= sh_b >> DATA_W;
      end
   end

endmodule
